// File: rtl/mesh_pkt_pkg.sv
// mesh_pkt_pkg
// Shared packet-format definitions for the mesh terminal sink.
//   - header field widths (fields are packed from the packet MSB downwards)
//   - default broadcast destination value
//   - pkt_hdr_t header view and dst_match_t classification result
//   - is_for_me(): destination decode against this terminal's coordinates
//   - sink_state_e: state encoding for the sink's pop controller
package mesh_pkt_pkg;

  localparam int NXT_JMP_W = 8;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int MODE_W    = 1;
  localparam int HDR_W     = NXT_JMP_W + ROW_W + COL_W + MODE_W;

  localparam logic [ROW_W+COL_W-1:0] BDCST_DEFAULT = 8'hFF;

  typedef struct packed {
    logic [NXT_JMP_W-1:0] nxt_jmp;
    logic [ROW_W-1:0]     dst_row;
    logic [COL_W-1:0]     dst_col;
    logic                 mode;
  } pkt_hdr_t;

  typedef struct packed {
    logic match;
    logic bcast;
  } dst_match_t;

  // An exact coordinate hit wins over the broadcast address, so bcast is only
  // reported when the packet reached us purely through the broadcast value.
  function automatic dst_match_t is_for_me(pkt_hdr_t hdr,
                                           logic [ROW_W-1:0] row,
                                           logic [COL_W-1:0] col,
                                           logic [ROW_W+COL_W-1:0] bdcst);
    dst_match_t res;
    logic       unicast;
    logic       bcast_hit;
    unicast   = ({hdr.dst_row, hdr.dst_col} == {row, col});
    bcast_hit = ({hdr.dst_row, hdr.dst_col} == bdcst);
    res.match = unicast | bcast_hit;
    res.bcast = bcast_hit & ~unicast;
    return res;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    STALL
  } sink_state_e;

endpackage

// File: rtl/mesh_sink_fifo.sv
// mesh_sink_fifo
// Synchronous show-ahead FIFO used as the sink's local receive buffer.
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset (clears pointers)
//   push, wr_data   enqueue request and data; accepted when not full, or when
//                   a pop is accepted in the same cycle
//   pop             dequeue request; ignored while empty
//   rd_data         head entry, forced to zero while empty
//   empty, full     occupancy flags
module mesh_sink_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB distinguishes a full buffer from an empty one when
  // the index bits coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is zeroed while empty so stale or never-written storage cannot leak
  // onto the consumer port after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers move independently so a push and a pop in
  // the same cycle leave the occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is deliberately left out of reset; the empty gating above hides it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mesh_term_sink.sv
// mesh_term_sink
// Terminal-side receiver for one mesh router output port. It pops packets off
// the router's show-ahead port, keeps those addressed to this terminal (or to
// the broadcast address) in a local FIFO, and drops/counts misdelivered ones.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   pndng          router has a packet at its head
//   data_out       router head packet, valid while pndng=1
//   pop            one-cycle strobe consuming the router head on this edge
//   rx_valid       local FIFO holds at least one packet
//   rx_data        local FIFO head packet, unmodified
//   rx_bcast       local FIFO head arrived via the broadcast address
//   rx_ready       consumer takes the head when rx_valid & rx_ready
//   rx_count       accepted packets, saturating
//   drop_count     misdelivered packets, saturating
//   err_sticky     set by the first misdelivery, cleared only by reset
module mesh_term_sink
  import mesh_pkt_pkg::*;
#(
  parameter int         ROWS      = 4,
  parameter int         COLUMNS   = 4,
  parameter int         PAKG_SIZE = 32,
  parameter int         BUF_DEPTH = 4,
  parameter logic [3:0] ROW_ID    = 4'd0,
  parameter logic [3:0] COL_ID    = 4'd0,
  parameter logic [7:0] BDCST     = BDCST_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pndng,
  input  logic [PAKG_SIZE-1:0] data_out,
  output logic                 pop,
  output logic                 rx_valid,
  output logic [PAKG_SIZE-1:0] rx_data,
  output logic                 rx_bcast,
  input  logic                 rx_ready,
  output logic [15:0]          rx_count,
  output logic [15:0]          drop_count,
  output logic                 err_sticky
);

  // A terminal placed outside the mesh can never be a unicast target, so only
  // broadcast traffic is accepted in that case.
  localparam bit COORD_OK = (int'(ROW_ID) < ROWS) && (int'(COL_ID) < COLUMNS);

  sink_state_e state_q;
  sink_state_e state_d;

  pkt_hdr_t   head_hdr;
  dst_match_t head_cls;
  logic       head_accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       deq;
  logic       push;

  assign head_hdr    = data_out[PAKG_SIZE-1 -: HDR_W];
  assign head_cls    = is_for_me(head_hdr, ROW_ID, COL_ID, BDCST);
  assign head_accept = head_cls.match & (head_cls.bcast | COORD_OK);

  assign rx_valid = ~fifo_empty;
  assign deq      = rx_valid & rx_ready;
  assign push     = pop & head_accept;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pop decision and next state. A misdelivered head needs no buffer space,
  // so it is popped even when the FIFO is full; a wanted head is popped only
  // when it has a slot (possibly the one freed by this cycle's dequeue).
  // Reset masks pop so the router head survives a reset untouched.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pndng) state_d = RECV;
      end
      RECV: begin
        pop = pndng & (~fifo_full | deq | ~head_accept);
        if (!pndng)    state_d = IDLE;
        else if (!pop) state_d = STALL;
      end
      STALL: begin
        if (~fifo_full | deq) state_d = RECV;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) pop = 1'b0;
  end

  // Statistics: each counter moves at most once per cycle and holds at max.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_count   <= '0;
      drop_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
      if (pop && !head_accept) begin
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        err_sticky <= 1'b1;
      end
    end
  end

  mesh_sink_fifo #(
    .WIDTH(PAKG_SIZE + 1),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (push),
    .wr_data({head_cls.bcast, data_out}),
    .pop    (deq),
    .rd_data({rx_bcast, rx_data}),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_mesh_term_sink.sv
// tb_mesh_term_sink
// Bench for mesh_term_sink (ROW_ID=1, COL_ID=2, BUF_DEPTH=4). A queue emulates
// the router port, a queue-based model predicts every output each cycle, and
// directed scenarios pin the model with hand-computed literal values.
module tb_mesh_term_sink;

  localparam int         PAKG_SIZE = 32;
  localparam int         BUF_DEPTH = 4;
  localparam logic [3:0] MY_ROW    = 4'd1;
  localparam logic [3:0] MY_COL    = 4'd2;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 pndng;
  logic [PAKG_SIZE-1:0] data_out;
  logic                 pop;
  logic                 rx_valid;
  logic [PAKG_SIZE-1:0] rx_data;
  logic                 rx_bcast;
  logic                 rx_ready;
  logic [15:0]          rx_count;
  logic [15:0]          drop_count;
  logic                 err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mesh_term_sink #(
    .ROWS     (4),
    .COLUMNS  (4),
    .PAKG_SIZE(PAKG_SIZE),
    .BUF_DEPTH(BUF_DEPTH),
    .ROW_ID   (MY_ROW),
    .COL_ID   (MY_COL),
    .BDCST    (8'hFF)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pndng     (pndng),
    .data_out  (data_out),
    .pop       (pop),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_bcast  (rx_bcast),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .drop_count(drop_count),
    .err_sticky(err_sticky)
  );

  // Router emulation state and consumer-side log of {bcast, packet}.
  logic [PAKG_SIZE-1:0] router_q[$];
  logic [PAKG_SIZE:0]   delivered[$];
  int                   pop_seen = 0;
  int                   run_len  = 0;
  int                   run_max  = 0;
  logic                 pop_pending = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [PAKG_SIZE-1:0] mkPkt(input logic [3:0] row, input logic [3:0] col,
                                                 input logic [14:0] payload);
    return {8'h00, row, col, 1'b0, payload};
  endfunction

  task automatic refreshPort();
    pndng    = (router_q.size() != 0);
    data_out = pndng ? router_q[0] : '0;
  endtask

  task automatic pushPkt(input logic [PAKG_SIZE-1:0] p);
    router_q.push_back(p);
    refreshPort();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic waitPops(input int target, input int budget);
    for (int i = 0; i < budget && pop_seen < target; i++) begin
      @(posedge clk_i);
      #2;
    end
    checkOutput("wait_pops_reached", 64'(pop_seen >= target), 64'd1);
  endtask

  task automatic checkDelivered(input string name, input int idx, input logic [PAKG_SIZE:0] expected);
    logic [PAKG_SIZE:0] got;
    got = (idx < delivered.size()) ? delivered[idx] : {1'b1, {PAKG_SIZE{1'b1}}};
    checkOutput(name, 64'(got), 64'(expected));
  endtask

  // Router side: pop is sampled mid-cycle and the head is consumed just after
  // the edge, then the port is re-presented. Consumer handshakes are logged.
  initial begin
    forever begin
      @(negedge clk_i);
      pop_pending = pop;
      if (pop) run_len++;
      else     run_len = 0;
      if (run_len > run_max) run_max = run_len;
      if (rx_valid && rx_ready && !rst_i) delivered.push_back({rx_bcast, rx_data});
      @(posedge clk_i);
      #1;
      if (pop_pending && router_q.size() != 0) begin
        void'(router_q.pop_front());
        pop_seen++;
      end
      refreshPort();
    end
  end

  // Behavioural model: a queue of accepted packets plus statistics, and a
  // simple notion of whether the sink is engaged with the port or parked
  // waiting for buffer room. Checked against the DUT every cycle.
  logic [PAKG_SIZE:0] m_q[$];
  int                 m_rx = 0;
  int                 m_drop = 0;
  bit                 m_err = 0;
  bit                 m_valid = 0;
  bit                 m_engaged = 0;
  bit                 m_parked = 0;

  always @(negedge clk_i) begin : model_check
    bit                 full;
    bit                 deq;
    bit                 for_me;
    bit                 is_bc;
    bit                 exp_pop;
    logic [7:0]         dst;
    logic [PAKG_SIZE:0] head;
    full    = (m_q.size() == BUF_DEPTH);
    deq     = (m_q.size() != 0) && rx_ready;
    dst     = data_out[23:16];
    for_me  = (dst == {MY_ROW, MY_COL});
    is_bc   = (dst == 8'hFF);
    exp_pop = !rst_i && pndng && m_engaged && (!full || deq || !(for_me || is_bc));
    if (rst_i || m_valid) checkOutput("model_pop", 64'(pop), 64'(exp_pop));
    if (m_valid) begin
      head = (m_q.size() != 0) ? m_q[0] : '0;
      checkOutput("model_rx_valid",   64'(rx_valid),   64'(m_q.size() != 0));
      checkOutput("model_rx_data",    64'(rx_data),    64'(head[PAKG_SIZE-1:0]));
      checkOutput("model_rx_bcast",   64'(rx_bcast),   64'(head[PAKG_SIZE]));
      checkOutput("model_rx_count",   64'(rx_count),   64'(m_rx));
      checkOutput("model_drop_count", 64'(drop_count), 64'(m_drop));
      checkOutput("model_err_sticky", 64'(err_sticky), 64'(m_err));
    end
    if (rst_i) begin
      m_q.delete();
      m_rx = 0; m_drop = 0; m_err = 0;
      m_engaged = 0; m_parked = 0; m_valid = 1;
    end else if (m_valid) begin
      if (deq) void'(m_q.pop_front());
      if (exp_pop) begin
        if (for_me || is_bc) begin
          m_q.push_back({is_bc && !for_me, data_out});
          if (m_rx < 65535) m_rx++;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_err = 1;
        end
      end
      if (m_parked) begin
        if (!full || deq) begin m_parked = 0; m_engaged = 1; end
      end else if (m_engaged) begin
        if (!pndng)        m_engaged = 0;
        else if (!exp_pop) begin m_engaged = 0; m_parked = 1; end
      end else begin
        m_engaged = pndng;
      end
    end
  end

  // Scenario driver.
  task automatic applyStimulus();
    int base;
    // Reset held two edges with a packet pending at the router.
    rst_i = 1'b1; rx_ready = 1'b1;
    pndng = 1'b0; data_out = '0;
    pushPkt(mkPkt(4'd1, 4'd2, 15'h001));
    @(posedge clk_i); #2;
    checkOutput("reset_pop_low", 64'(pop), 64'd0);
    @(posedge clk_i); #2;
    checkOutput("reset_pop_low2", 64'(pop), 64'd0);
    rst_i = 1'b0;
    checkOutput("reset_rx_valid", 64'(rx_valid), 64'd0);
    checkOutput("reset_rx_data", 64'(rx_data), 64'd0);
    checkOutput("reset_counts", 64'({rx_count, drop_count, err_sticky}), 64'd0);
    checkOutput("reset_no_pop_yet", 64'(pop_seen), 64'd0);
    waitPops(1, 5);
    waitCycles(3);

    // Unicast stream after a fresh reset so the counters start at zero.
    rst_i = 1'b1;
    waitCycles(1);
    rst_i = 1'b0;
    delivered.delete(); run_max = 0;
    pushPkt(mkPkt(4'd1, 4'd2, 15'h00A));
    pushPkt(mkPkt(4'd1, 4'd2, 15'h00B));
    pushPkt(mkPkt(4'd1, 4'd2, 15'h00C));
    waitCycles(8);
    checkOutput("uni_pop_run", 64'(run_max), 64'd3);
    checkOutput("uni_rx_count", 64'(rx_count), 64'd3);
    checkOutput("uni_drop_count", 64'(drop_count), 64'd0);
    checkDelivered("uni_order0", 0, {1'b0, 32'h0012_000A});
    checkDelivered("uni_order1", 1, {1'b0, 32'h0012_000B});
    checkDelivered("uni_order2", 2, {1'b0, 32'h0012_000C});

    // Broadcast.
    delivered.delete();
    pushPkt(mkPkt(4'hF, 4'hF, 15'h01B));
    waitCycles(5);
    checkOutput("bc_rx_count", 64'(rx_count), 64'd4);
    checkDelivered("bc_flagged", 0, {1'b1, 32'h00FF_001B});

    // Misroute, then a valid packet afterwards.
    delivered.delete();
    pushPkt(mkPkt(4'd2, 4'd2, 15'h055));
    waitCycles(4);
    checkOutput("mis_drop_count", 64'(drop_count), 64'd1);
    checkOutput("mis_err_sticky", 64'(err_sticky), 64'd1);
    checkOutput("mis_not_delivered", 64'(delivered.size()), 64'd0);
    pushPkt(mkPkt(4'd1, 4'd2, 15'h066));
    waitCycles(4);
    checkOutput("mis_after_rx_count", 64'(rx_count), 64'd5);
    checkOutput("mis_err_stays", 64'(err_sticky), 64'd1);
    checkDelivered("mis_after_pkt", 0, {1'b0, 32'h0012_0066});

    // Backpressure: six wanted packets with the consumer stalled.
    delivered.delete();
    rx_ready = 1'b0;
    base = pop_seen;
    for (int i = 0; i < 6; i++) pushPkt(mkPkt(4'd1, 4'd2, 15'(16'h100 + i)));
    waitCycles(10);
    checkOutput("bp_four_pops", 64'(pop_seen - base), 64'd4);
    checkOutput("bp_pop_low", 64'(pop), 64'd0);
    checkOutput("bp_head", 64'(rx_data), 64'h0012_0100);
    rx_ready = 1'b1;
    waitPops(base + 6, 20);
    waitCycles(6);
    checkOutput("bp_delivered", 64'(delivered.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      checkDelivered("bp_order", i, {1'b0, 32'h0012_0100 + 32'(i)});
    checkOutput("bp_rx_count", 64'(rx_count), 64'd11);

    // Full buffer: a misroute head is still dropped, then push+dequeue together.
    delivered.delete();
    rx_ready = 1'b0;
    base = pop_seen;
    for (int i = 0; i < 4; i++) pushPkt(mkPkt(4'd1, 4'd2, 15'(16'h200 + i)));
    pushPkt(mkPkt(4'd3, 4'd3, 15'h077));
    pushPkt(mkPkt(4'd1, 4'd2, 15'h204));
    pushPkt(mkPkt(4'd1, 4'd2, 15'h205));
    waitPops(base + 5, 20);
    checkOutput("full_drop_count", 64'(drop_count), 64'd2);
    checkOutput("full_still_valid", 64'(rx_valid), 64'd1);
    rx_ready = 1'b1;
    waitPops(base + 6, 3);
    rx_ready = 1'b0;
    waitCycles(4);
    checkOutput("full_occupancy_kept", 64'(pop_seen - base), 64'd6);
    checkOutput("full_stall_pop_low", 64'(pop), 64'd0);
    checkOutput("full_one_dequeued", 64'(delivered.size()), 64'd1);
    rx_ready = 1'b1;
    waitCycles(12);
    checkOutput("full_delivered", 64'(delivered.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      checkDelivered("full_order", i, {1'b0, 32'h0012_0200 + 32'(i)});
    checkOutput("full_rx_count", 64'(rx_count), 64'd17);
    checkOutput("full_drop_final", 64'(drop_count), 64'd2);
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
